aes_core_arbiter: RTL and testbench
===================================

# aes_core_arbiter

Shares one AES-128 processing core between two independent requesters. Each requester hands over a plaintext block and key on a valid/ready channel. The arbiter grants one requester at a time in round-robin order, pulses the core's start, and holds the operands stable until the core signals done. It then returns the ciphertext to the granted requester on a valid/ready response channel. A watchdog counter limits how long the arbiter waits on the core.

## Interface
Parameters:
- TIMEOUT_CYCLES, 32: core cycles allowed between start and done; must be ≥ 22 and ≤ 63
- CNT_W, 6: watchdog counter width

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- req_valid  in  2  per-requester block offered (bit i = requester i)
- req_ready  out  2  per-requester block accepted this cycle
- req_data0, req_data1  in  128  plaintext block, requester 0 / 1
- req_key0, req_key1  in  128  cipher key, requester 0 / 1
- rsp_valid  out  2  ciphertext available for requester i
- rsp_ready  in  2  requester i takes the ciphertext
- rsp_data  out  128  ciphertext, shared by both response channels
- core_start  out  1  one-cycle start pulse to the core
- core_data  out  128  plaintext to the core, held stable from start to done
- core_key  out  128  key to the core, held stable from start to done
- core_done  in  1  one-cycle completion pulse from the core
- core_result  in  128  ciphertext, valid in the cycle core_done is high
- timeout_err  out  1  sticky error flag; cleared only by reset

## Operation
State machine: IDLE → ISSUE → BUSY → RESP → IDLE. BUSY may also leave directly to IDLE on timeout.

- **IDLE**
  - If any req_valid bit is set, grant one requester: the one with req_valid set; if both are set, the one selected by rr_ptr.
  - req_ready[grant] = 1 combinationally in this cycle only.
  - Capture the granted requester's data and key into operand registers; owner ← grant; go to ISSUE.
- **ISSUE**
  - core_start = 1 for exactly one cycle.
  - Clear the watchdog counter; go to BUSY.
- **BUSY**
  - Increment the watchdog counter every cycle.
  - On core_done: rsp_reg ← core_result; go to RESP.
  - Else, when the counter reaches TIMEOUT_CYCLES−1: set timeout_err, drop the job with no response, rr_ptr ← ~owner, go to IDLE.
- **RESP**
  - rsp_valid[owner] = 1; rsp_data = rsp_reg.
  - On rsp_ready[owner]: rr_ptr ← ~owner; go to IDLE.
  - rsp_ready[~owner] is ignored.

Output rules:
- core_data and core_key always drive the operand registers, which change only at an IDLE handshake.
- rsp_valid is 0 in every state except RESP.

## Timing
- **Reset values:** state = IDLE; req_ready = 0; rsp_valid = 0; core_start = 0; timeout_err = 0; rr_ptr = 0; owner = 0; operand registers, rsp_reg and counter all 0; rsp_data = 0.
- **Latency:**
  - Handshake at cycle T → core_start at T+1.
  - core_done at cycle D → rsp_valid rises at D+1.
  - Earliest next grant is the cycle after the response handshake.
- **No back-to-back acceptance:** at most one job is in flight; req_ready is never high outside IDLE.
- **Both req_valid high in IDLE:** rr_ptr wins. The requester that was not served keeps its data and stays valid; it is accepted in the next IDLE, even if the served requester reasserts valid.
- **core_done outside BUSY:** ignored; no state change and no data captured.
- **core_done in the same cycle the counter expires:** done wins; no error is raised.
- **rsp_ready asserted before rsp_valid:** has no effect; completion requires both high in the same cycle.
- **Reset asserted mid-operation:** everything returns to reset values immediately. The in-flight job is lost. The core is reset by the same signal.
- **Counter arithmetic:** CNT_W bits, unsigned; it saturates and never wraps, because expiry forces exit from BUSY first.

## Structure
Shared package aes_pkg holds:
- AES_BLOCK_W = 128
- arbiter state encoding: IDLE = 2'b00, ISSUE = 2'b01, BUSY = 2'b10, RESP = 2'b11

One sub-module, rr_arbiter2:
- purely combinational 2-way round-robin pick
- inputs: req[1:0], ptr
- outputs: gnt[1:0], gnt_idx

The FSM, operand and response registers, watchdog counter and rr_ptr live in aes_core_arbiter.

## Test plan
- **FIPS-197 single job:** requester 0 offers plaintext 00112233445566778899aabbccddeeff with key 000102030405060708090a0b0c0d0e0f, rsp_ready tied high.
  - Expect req_ready[0] one cycle, core_start one cycle later, and rsp_valid[0] with rsp_data 69c4e0d86a7b0430d8cdb78070b4c55a.
- **Contention:** both requesters valid at the same cycle after reset.
  - Requester 0 is served first, requester 1 next; rr_ptr then returns to 0.
  - Repeat three times and check the grants alternate 0,1,0,1,0,1.
- **Response backpressure:** hold rsp_ready[1] low for 10 cycles while rsp_valid[1] is high, and pulse rsp_ready[0] during that time.
  - Expect rsp_data held constant, no new req_ready, and the response completing only on rsp_ready[1].
- **Timeout:** use a core stub that never pulses done.
  - Expect timeout_err = 1 exactly TIMEOUT_CYCLES cycles after core_start, no rsp_valid, and the next request then granted normally.
- **Reset mid-BUSY:** drop reset 5 cycles after core_start.
  - Expect all outputs at reset values in that same cycle.
  - After releasing reset, a new job completes correctly; a stale core_done injected in IDLE is ignored.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared definitions for the AES core arbiter: block width and FSM state encoding.
package aes_pkg;

  localparam int AES_BLOCK_W = 128;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    BUSY  = 2'b10,
    RESP  = 2'b11
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Combinational two-way round-robin pick: a lone requester wins, ties go to ptr.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt,
  output logic       gnt_idx
);

  // Select the winning index, then expand it to a one-hot grant.
  always_comb begin
    gnt_idx = 1'b0;
    case (req)
      2'b01:   gnt_idx = 1'b0;
      2'b10:   gnt_idx = 1'b1;
      2'b11:   gnt_idx = ptr;
      default: gnt_idx = 1'b0;
    endcase
    if (req == 2'b00) begin
      gnt = 2'b00;
    end else begin
      gnt = gnt_idx ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/aes_core_arbiter.sv
// Shares one AES-128 core between two valid/ready requesters, round-robin,
// with a watchdog that abandons a job if the core never reports done.
module aes_core_arbiter
  import aes_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 32,
  parameter int CNT_W          = 6
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             req_valid,
  output logic [1:0]             req_ready,
  input  logic [AES_BLOCK_W-1:0] req_data0,
  input  logic [AES_BLOCK_W-1:0] req_data1,
  input  logic [AES_BLOCK_W-1:0] req_key0,
  input  logic [AES_BLOCK_W-1:0] req_key1,
  output logic [1:0]             rsp_valid,
  input  logic [1:0]             rsp_ready,
  output logic [AES_BLOCK_W-1:0] rsp_data,
  output logic                   core_start,
  output logic [AES_BLOCK_W-1:0] core_data,
  output logic [AES_BLOCK_W-1:0] core_key,
  input  logic                   core_done,
  input  logic [AES_BLOCK_W-1:0] core_result,
  output logic                   timeout_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] EXPIRE  = CNT_W'(TIMEOUT_CYCLES - 1);

  arb_state_e             state_q, state_d;
  logic                   rr_ptr_q, rr_ptr_d;
  logic                   owner_q, owner_d;
  logic [AES_BLOCK_W-1:0] op_data_q, op_data_d;
  logic [AES_BLOCK_W-1:0] op_key_q, op_key_d;
  logic [AES_BLOCK_W-1:0] rsp_q, rsp_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   timeout_err_q, timeout_err_d;
  logic [CNT_W-1:0]       cnt_inc;
  logic [1:0]             gnt;
  logic                   gnt_idx;

  rr_arbiter2 u_rr (
    .req     (req_valid),
    .ptr     (rr_ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // Saturating increment; expiry forces BUSY to exit long before the counter tops out.
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      rr_ptr_q      <= 1'b0;
      owner_q       <= 1'b0;
      op_data_q     <= {AES_BLOCK_W{1'b0}};
      op_key_q      <= {AES_BLOCK_W{1'b0}};
      rsp_q         <= {AES_BLOCK_W{1'b0}};
      cnt_q         <= {CNT_W{1'b0}};
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      owner_q       <= owner_d;
      op_data_q     <= op_data_d;
      op_key_q      <= op_key_d;
      rsp_q         <= rsp_d;
      cnt_q         <= cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    owner_d       = owner_q;
    op_data_d     = op_data_q;
    op_key_d      = op_key_q;
    rsp_d         = rsp_q;
    cnt_d         = cnt_q;
    timeout_err_d = timeout_err_q;
    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          owner_d   = gnt_idx;
          op_data_d = gnt_idx ? req_data1 : req_data0;
          op_key_d  = gnt_idx ? req_key1 : req_key0;
          state_d   = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        cnt_d   = {CNT_W{1'b0}};
        state_d = BUSY;
      end
      BUSY: begin
        cnt_d = cnt_inc;
        // A done arriving in the expiry cycle still completes the job.
        if (core_done) begin
          rsp_d   = core_result;
          state_d = RESP;
        end else if (cnt_inc == EXPIRE) begin
          timeout_err_d = 1'b1;
          rr_ptr_d      = ~owner_q;
          state_d       = IDLE;
        end else begin
          state_d = BUSY;
        end
      end
      RESP: begin
        if (rsp_ready[owner_q]) begin
          rr_ptr_d = ~owner_q;
          state_d  = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake and control outputs decoded from the current state.
  always_comb begin
    req_ready  = 2'b00;
    rsp_valid  = 2'b00;
    core_start = 1'b0;
    case (state_q)
      IDLE:    req_ready  = gnt;
      ISSUE:   core_start = 1'b1;
      BUSY:    core_start = 1'b0;
      RESP:    rsp_valid  = owner_q ? 2'b10 : 2'b01;
      default: core_start = 1'b0;
    endcase
  end

  assign rsp_data    = rsp_q;
  assign core_data   = op_data_q;
  assign core_key    = op_key_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_aes_core_arbiter.sv
// Randomized self-checking bench for aes_core_arbiter with a latency-programmable core stub.
module tb_aes_core_arbiter;

  localparam int TIMEOUT = 32;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
  logic [127:0] req_data0, req_data1, req_key0, req_key1;
  logic [127:0] rsp_data, core_data, core_key, core_result;
  logic         core_start, core_done, timeout_err;

  logic         stub_done, stub_pend, inj_done;
  logic [127:0] stub_res;
  int           stub_cnt;
  int           stub_lat;
  bit           stub_hang;

  int n_checks = 0;
  int n_fail   = 0;
  int rr_m     = 0;
  int grants[$];

  aes_core_arbiter #(.TIMEOUT_CYCLES(TIMEOUT), .CNT_W(6)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_data0(req_data0), .req_data1(req_data1),
    .req_key0(req_key0), .req_key1(req_key1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .core_start(core_start), .core_data(core_data), .core_key(core_key),
    .core_done(core_done), .core_result(core_result), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Stand-in for the AES core: real vector for FIPS-197, a fixed mix otherwise.
  function automatic logic [127:0] core_fn(input logic [127:0] d, input logic [127:0] k);
    if (d == FIPS_PT && k == FIPS_KEY) return FIPS_CT;
    return {d[63:0] ^ k[127:64], d[127:64] + k[63:0]};
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Core stub: done fires stub_lat+2 cycles after start; result is garbage outside done.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      stub_done <= 1'b0;
      stub_pend <= 1'b0;
      stub_cnt  <= 0;
      stub_res  <= 128'h0;
    end else begin
      stub_done <= 1'b0;
      stub_res  <= rnd128();
      if (core_start) begin
        stub_pend <= !stub_hang;
        stub_cnt  <= stub_lat;
      end else if (stub_pend) begin
        if (stub_cnt == 0) begin
          stub_done <= 1'b1;
          stub_res  <= core_fn(core_data, core_key);
          stub_pend <= 1'b0;
        end else begin
          stub_cnt <= stub_cnt - 1;
        end
      end
    end
  end

  assign core_done   = stub_done | inj_done;
  assign core_result = stub_res;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drives one job end to end; caller calls it #1 after a posedge with valids set.
  task automatic serve(input bit exp_to, input int lat, input int hold);
    int pick, n;
    bit got, bad;
    logic [1:0] exp_g;
    logic [127:0] d, k, r;
    stub_lat  = lat;
    stub_hang = exp_to;
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      got = (req_ready != 2'b00);
    end
    check_eq("grant_seen", got, 1'b1);
    if (!got) return;
    check_eq("rsp_idle", rsp_valid, 2'b00);
    pick  = (req_valid == 2'b11) ? rr_m : (req_valid[1] ? 1 : 0);
    exp_g = (pick == 1) ? 2'b10 : 2'b01;
    check_eq("grant", req_ready, exp_g);
    d = (pick == 1) ? req_data1 : req_data0;
    k = (pick == 1) ? req_key1 : req_key0;
    r = core_fn(d, k);
    grants.push_back(pick);
    @(posedge clk); #1;
    req_valid[pick] = 1'b0;
    @(negedge clk);
    check_eq("core_start", core_start, 1'b1);
    check_eq("core_data", core_data, d);
    check_eq("core_key", core_key, k);
    check_eq("ready_issue", req_ready, 2'b00);
    if (exp_to) check_eq("err_before", timeout_err, 1'b0);
    bad = 1'b0;
    got = 1'b0;
    n   = 0;
    while (!got && n < 80) begin
      @(negedge clk);
      n++;
      if (req_ready != 2'b00 || core_start) bad = 1'b1;
      if (exp_to) begin
        if (rsp_valid != 2'b00) bad = 1'b1;
        got = timeout_err;
      end else begin
        got = (rsp_valid != 2'b00);
      end
    end
    check_eq("wait_bound", got, 1'b1);
    check_eq("quiet_busy", bad, 1'b0);
    if (exp_to) begin
      check_eq("timeout_lat", n, TIMEOUT);
      rr_m = 1 - pick;
      @(posedge clk); #1;
      return;
    end
    check_eq("rsp_owner", rsp_valid, exp_g);
    check_eq("rsp_data", rsp_data, r);
    check_eq("rsp_lat", n, lat + 3);
    if (hold > 0) begin
      for (int j = 0; j < hold; j++) begin
        rsp_ready[1 - pick] = (j % 2 == 0);
        @(negedge clk);
        if (rsp_valid != exp_g || rsp_data != r || req_ready != 2'b00) bad = 1'b1;
      end
      check_eq("rsp_hold", bad, 1'b0);
    end
    rsp_ready[pick] = 1'b1;
    rr_m = 1 - pick;
    @(posedge clk); #1;
    rsp_ready = 2'b11;
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b0;
    @(negedge clk); reset = 1'b1;
    rr_m = 0;
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b0; req_valid = 2'b00; rsp_ready = 2'b11; inj_done = 1'b0;
    req_data0 = 128'h0; req_data1 = 128'h0; req_key0 = 128'h0; req_key1 = 128'h0;
    stub_lat = 0; stub_hang = 1'b0;
    #12;
    check_eq("rst_req_ready", req_ready, 2'b00);
    check_eq("rst_rsp_valid", rsp_valid, 2'b00);
    check_eq("rst_core_start", core_start, 1'b0);
    check_eq("rst_timeout", timeout_err, 1'b0);
    check_eq("rst_rsp_data", rsp_data, 128'h0);
    check_eq("rst_core_data", core_data, 128'h0);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;

    // FIPS-197 single job from requester 0.
    req_data0 = FIPS_PT; req_key0 = FIPS_KEY; req_valid = 2'b01;
    serve(1'b0, 9, 0);

    // Random traffic; one job hits done exactly in the expiry cycle.
    for (int it = 0; it < 12; it++) begin
      if (!req_valid[0] && $urandom_range(0, 1) == 1) begin
        req_data0 = rnd128(); req_key0 = rnd128(); req_valid[0] = 1'b1;
      end
      if (!req_valid[1] && $urandom_range(0, 1) == 1) begin
        req_data1 = rnd128(); req_key1 = rnd128(); req_valid[1] = 1'b1;
      end
      if (req_valid == 2'b00) begin
        req_data1 = rnd128(); req_key1 = rnd128(); req_valid[1] = 1'b1;
      end
      serve(1'b0, (it == 5) ? TIMEOUT - 3 : int'($urandom_range(0, 20)), 0);
    end
    check_eq("no_err_boundary", timeout_err, 1'b0);
    for (int i = 0; i < 2 && req_valid != 2'b00; i++) serve(1'b0, 2, 0);

    // Contention from reset: grants must alternate 0,1,0,1,0,1.
    do_reset();
    grants.delete();
    req_data0 = rnd128(); req_key0 = rnd128(); req_data1 = rnd128(); req_key1 = rnd128();
    req_valid = 2'b11;
    for (int i = 0; i < 6; i++) begin
      serve(1'b0, int'($urandom_range(0, 10)), 0);
      if (i < 5 && grants.size() > 0) begin
        if (grants[grants.size() - 1] == 0) begin
          req_data0 = rnd128(); req_key0 = rnd128(); req_valid[0] = 1'b1;
        end else begin
          req_data1 = rnd128(); req_key1 = rnd128(); req_valid[1] = 1'b1;
        end
      end
    end
    check_eq("contention_count", grants.size(), 6);
    for (int i = 0; i < grants.size(); i++) check_eq("contention_order", grants[i], i % 2);
    serve(1'b0, 4, 0);

    // Backpressure on requester 1 while requester 0 waits.
    rsp_ready = 2'b00;
    req_data0 = rnd128(); req_key0 = rnd128(); req_data1 = rnd128(); req_key1 = rnd128();
    req_valid = 2'b11;
    serve(1'b0, 3, 10);
    serve(1'b0, 5, 0);

    // Timeout from requester 1, then a normal grant.
    req_data1 = rnd128(); req_key1 = rnd128(); req_valid = 2'b10;
    serve(1'b1, 0, 0);
    check_eq("err_sticky", timeout_err, 1'b1);
    req_data0 = rnd128(); req_key0 = rnd128(); req_data1 = rnd128(); req_key1 = rnd128();
    req_valid = 2'b11;
    serve(1'b0, 6, 0);
    serve(1'b0, 1, 0);

    // Reset five cycles into BUSY.
    stub_lat = 25; stub_hang = 1'b0;
    req_data0 = rnd128(); req_key0 = rnd128(); req_valid = 2'b01;
    @(negedge clk);
    check_eq("mid_grant", req_ready, 2'b01);
    @(posedge clk); #1;
    req_valid = 2'b00;
    @(negedge clk);
    check_eq("mid_start", core_start, 1'b1);
    repeat (5) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check_eq("mid_rsp_valid", rsp_valid, 2'b00);
    check_eq("mid_core_start", core_start, 1'b0);
    check_eq("mid_timeout", timeout_err, 1'b0);
    check_eq("mid_core_data", core_data, 128'h0);
    check_eq("mid_core_key", core_key, 128'h0);
    check_eq("mid_rsp_data", rsp_data, 128'h0);
    @(negedge clk); reset = 1'b1;
    rr_m = 0;
    @(posedge clk); #1; inj_done = 1'b1;
    @(negedge clk);
    check_eq("stale_rsp_valid", rsp_valid, 2'b00);
    @(posedge clk); #1; inj_done = 1'b0;
    @(negedge clk);
    check_eq("stale_rsp_valid2", rsp_valid, 2'b00);
    check_eq("stale_rsp_data", rsp_data, 128'h0);
    check_eq("stale_core_start", core_start, 1'b0);
    @(posedge clk); #1;
    req_data1 = rnd128(); req_key1 = rnd128(); req_valid = 2'b10;
    serve(1'b0, int'($urandom_range(0, 20)), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
